// File: rtl/fwd_hazard_unit.sv
// Forwarding, load-use and mult/div scoreboard unit for the 5-stage core.
// Optional build macro MW_BYPASS_EN enables the MW->DX bypass path; without it, MW matches stall instead.
module fwd_hazard_unit #(
    parameter int DATA_W   = 32,
    parameter int REG_AW   = 5,
    parameter int MD_LAT   = 34,
    parameter int STAT_REG = 30
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [REG_AW-1:0] fd_rs,
    input  logic [REG_AW-1:0] fd_rt,
    input  logic              fd_rs_use,
    input  logic              fd_rt_use,
    input  logic              fd_is_md,
    input  logic [REG_AW-1:0] dx_rs,
    input  logic [REG_AW-1:0] dx_rt,
    input  logic              dx_rs_use,
    input  logic              dx_rt_use,
    input  logic [REG_AW-1:0] dx_rd,
    input  logic              dx_wen,
    input  logic              dx_is_load,
    input  logic              dx_is_md,
    input  logic [DATA_W-1:0] dx_a,
    input  logic [DATA_W-1:0] dx_b,
    input  logic [REG_AW-1:0] xm_rd,
    input  logic              xm_wen,
    input  logic [DATA_W-1:0] xm_o,
    input  logic [REG_AW-1:0] mw_rd,
    input  logic              mw_wen,
    input  logic [DATA_W-1:0] mw_data,
    input  logic              md_ready,
    input  logic              md_exc,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic              stall_fd,
    output logic              bubble_dx,
    output logic              md_busy,
    output logic              md_wb,
    output logic [REG_AW-1:0] md_rd,
    output logic              md_status
);

`ifdef MW_BYPASS_EN
    localparam bit MW_FWD = 1'b1;
`else
    localparam bit MW_FWD = 1'b0;
`endif

    localparam int CNT_W = $clog2(MD_LAT + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MD_LAT - 1);
    localparam logic [REG_AW-1:0] STAT_RD  = REG_AW'(STAT_REG);
    localparam logic [REG_AW-1:0] ZERO_RD  = '0;

    typedef enum logic [1:0] {
        MD_IDLE,
        MD_BUSY,
        MD_WB
    } md_state_t;

    md_state_t         md_state;
    logic [CNT_W-1:0]  cnt;

    logic xm_a_hit, xm_b_hit, mw_a_hit, mw_b_hit;
    logic load_use, md_stall, mw_stall;
    logic fd_reads_md, fd_reads_stat;

    // Register 0 never matches, so an r0 source always takes the DX latch value.
    always_comb begin
        xm_a_hit = dx_rs_use && (dx_rs != ZERO_RD) && xm_wen && (xm_rd == dx_rs);
        xm_b_hit = dx_rt_use && (dx_rt != ZERO_RD) && xm_wen && (xm_rd == dx_rt);
        mw_a_hit = dx_rs_use && (dx_rs != ZERO_RD) && mw_wen && (mw_rd == dx_rs);
        mw_b_hit = dx_rt_use && (dx_rt != ZERO_RD) && mw_wen && (mw_rd == dx_rt);

        alu_a = dx_a;
        if (xm_a_hit)
            alu_a = xm_o;
        else if (MW_FWD && mw_a_hit)
            alu_a = mw_data;

        alu_b = dx_b;
        if (xm_b_hit)
            alu_b = xm_o;
        else if (MW_FWD && mw_b_hit)
            alu_b = mw_data;

        // Without the MW path, wait one cycle so the register file write lands first.
        mw_stall = !MW_FWD && ((mw_a_hit && !xm_a_hit) || (mw_b_hit && !xm_b_hit));
    end

    always_comb begin
        load_use = dx_is_load && dx_wen && (dx_rd != ZERO_RD) &&
                   ((fd_rs_use && (fd_rs == dx_rd)) || (fd_rt_use && (fd_rt == dx_rd)));

        fd_reads_md = (md_rd != ZERO_RD) &&
                      ((fd_rs_use && (fd_rs == md_rd)) || (fd_rt_use && (fd_rt == md_rd)));
        fd_reads_stat = (fd_rs_use && (fd_rs == STAT_RD)) || (fd_rt_use && (fd_rt == STAT_RD));

        md_stall = md_busy && (fd_is_md || fd_reads_md || fd_reads_stat);

        stall_fd  = load_use || md_stall || mw_stall;
        bubble_dx = stall_fd;
    end

    // Scoreboard for the single in-flight mult/div; a timeout is reported like an exception.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            md_state  <= MD_IDLE;
            cnt       <= '0;
            md_rd     <= '0;
            md_busy   <= 1'b0;
            md_wb     <= 1'b0;
            md_status <= 1'b0;
        end else begin
            case (md_state)
                MD_IDLE: begin
                    md_wb <= 1'b0;
                    if (dx_is_md && !bubble_dx) begin
                        md_state  <= MD_BUSY;
                        md_rd     <= dx_rd;
                        cnt       <= '0;
                        md_busy   <= 1'b1;
                        md_status <= 1'b0;
                    end
                end
                MD_BUSY: begin
                    cnt <= cnt + 1'b1;
                    if (md_ready) begin
                        md_state  <= MD_WB;
                        md_wb     <= 1'b1;
                        md_status <= md_exc;
                    end else if (cnt == CNT_LAST) begin
                        md_state  <= MD_WB;
                        md_wb     <= 1'b1;
                        md_status <= 1'b1;
                    end
                end
                MD_WB: begin
                    md_state <= MD_IDLE;
                    md_wb    <= 1'b0;
                    md_busy  <= 1'b0;
                end
                default: begin
                    md_state <= MD_IDLE;
                    md_wb    <= 1'b0;
                    md_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
